// File: rtl/enc_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The master side drives the requests, and the slave (arbiter) side drives the grant.
interface enc_arbiter_if #(
    parameter int NREQ = 8,
    parameter int IDXW = 3
);
    logic [NREQ-1:0] req_value;
    logic            EN_release;
    logic [NREQ-1:0] gnt_value;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_valid;
    logic            RDY_release;
    logic            timeout_pulse;

    modport master (
        output req_value, EN_release,
        input  gnt_value, gnt_idx, gnt_valid, RDY_release, timeout_pulse
    );

    modport slave (
        input  req_value, EN_release,
        output gnt_value, gnt_idx, gnt_valid, RDY_release, timeout_pulse
    );
endinterface

// File: rtl/enc_arbiter.sv
// Round-robin arbiter for eight requesters with registered one-hot grant plus encoded index.
// A grant ends on release, owner request drop or hold expiry, then one turnaround cycle follows.
module enc_arbiter #(
    parameter int NREQ     = 8,
    parameter int IDXW     = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    enc_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    // First requester at or after base, wrapping; MSB flags that any request was found.
    function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [IDXW-1:0] base);
        logic            found;
        logic [IDXW-1:0] win;
        logic [IDXW-1:0] idx;
        found = 1'b0;
        win   = {IDXW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            idx   = base + IDXW'(i);
            win   = (!found && req[idx]) ? idx : win;
            found = found | req[idx];
        end
        return {found, win};
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
        return {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    state_t          state_r,     state_nxt_s;
    logic [IDXW-1:0] ptr_r,       ptr_nxt_s;
    logic [7:0]      hcnt_r,      hcnt_nxt_s;
    logic [IDXW-1:0] owner_r,     owner_nxt_s;
    logic [NREQ-1:0] gnt_value_r, gnt_value_nxt_s;
    logic [IDXW-1:0] gnt_idx_r,   gnt_idx_nxt_s;
    logic            gnt_valid_r, gnt_valid_nxt_s;
    logic            timeout_r,   timeout_nxt_s;

    logic [IDXW:0]   pick_s;
    logic            pick_found_s;
    logic [IDXW-1:0] pick_idx_s;
    logic            rel_s;
    logic            exp_s;

    assign pick_s       = rr_pick(bus.req_value, ptr_r);
    assign pick_found_s = pick_s[IDXW];
    assign pick_idx_s   = pick_s[IDXW-1:0];
    // Dropping the owner's own request counts as a release.
    assign rel_s        = bus.EN_release | ~bus.req_value[owner_r];
    assign exp_s        = (hcnt_r == HOLD_LAST);

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decision.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (rel_s || exp_s) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            ST_GAP:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the datapath and of the registered outputs.
    always_comb begin
        ptr_nxt_s       = ptr_r;
        hcnt_nxt_s      = 8'd0;
        owner_nxt_s     = owner_r;
        gnt_value_nxt_s = {NREQ{1'b0}};
        gnt_idx_nxt_s   = {IDXW{1'b0}};
        gnt_valid_nxt_s = 1'b0;
        timeout_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    owner_nxt_s     = pick_idx_s;
                    gnt_value_nxt_s = onehot(pick_idx_s);
                    gnt_idx_nxt_s   = pick_idx_s;
                    gnt_valid_nxt_s = 1'b1;
                end else begin
                    owner_nxt_s     = owner_r;
                end
            end
            ST_GRANT: begin
                if (rel_s || exp_s) begin
                    // Release wins over a coincident expiry, so no timeout flag then.
                    ptr_nxt_s     = owner_r + {{(IDXW-1){1'b0}}, 1'b1};
                    timeout_nxt_s = ~rel_s & exp_s;
                end else begin
                    hcnt_nxt_s      = hcnt_r + 8'd1;
                    gnt_value_nxt_s = gnt_value_r;
                    gnt_idx_nxt_s   = gnt_idx_r;
                    gnt_valid_nxt_s = gnt_valid_r;
                end
            end
            ST_GAP:  ptr_nxt_s = ptr_r;
            default: ptr_nxt_s = ptr_r;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_r       <= {IDXW{1'b0}};
            hcnt_r      <= 8'd0;
            owner_r     <= {IDXW{1'b0}};
            gnt_value_r <= {NREQ{1'b0}};
            gnt_idx_r   <= {IDXW{1'b0}};
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            ptr_r       <= ptr_nxt_s;
            hcnt_r      <= hcnt_nxt_s;
            owner_r     <= owner_nxt_s;
            gnt_value_r <= gnt_value_nxt_s;
            gnt_idx_r   <= gnt_idx_nxt_s;
            gnt_valid_r <= gnt_valid_nxt_s;
            timeout_r   <= timeout_nxt_s;
        end
    end

    assign bus.gnt_value     = gnt_value_r;
    assign bus.gnt_idx       = gnt_idx_r;
    assign bus.gnt_valid     = gnt_valid_r;
    assign bus.RDY_release   = gnt_valid_r;
    assign bus.timeout_pulse = timeout_r;

endmodule

// File: doc/enc_arbiter.md
# enc_arbiter

Round-robin arbiter that shares one downstream resource among eight requesters. It drives a registered one-hot grant and its 3-bit encoded index, in the same one-hot/index form our 8-to-3 encoder produces. Each grant ends on owner release, on the owner dropping its request, or on a hold-timeout. The arbiter sits in front of the shared encoder/transmit link and sequences which source owns it.

## Interface
- NREQ, 8: number of requesters; fixed at 8 in this revision.
- IDXW, 3: width of the encoded grant index.
- MAX_HOLD, 16: maximum cycles one grant may be held; legal range 1..255.

- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- req_value  in  8  request vector; bit i = requester i wants the resource.
- EN_release  in  1  current owner releases the grant; honoured only while RDY_release=1.
- gnt_value  out  8  one-hot grant; all zero when no grant is held.
- gnt_idx  out  3  encoded index of the granted requester; 0 when no grant is held.
- gnt_valid  out  1  a grant is held.
- RDY_release  out  1  equals gnt_valid.
- timeout_pulse  out  1  one-cycle flag: the previous grant ended by hold expiry.

## Operation
- State machine has three states: IDLE, GRANT, GAP. Internal registers:
  - 3-bit round-robin pointer ptr.
  - 8-bit hold counter hcnt.
  - 3-bit owner index.
- **IDLE**
  - If req_value != 0, the winner is the first set bit found searching ptr, ptr+1, …, 7, 0, …, ptr-1 (wraps mod 8).
  - At the next edge: state -> GRANT, gnt_value = one-hot(winner), gnt_idx = winner, gnt_valid = 1, hcnt = 0.
  - If req_value == 0, stay in IDLE.
- **GRANT**
  - hcnt increments every cycle.
  - Exit conditions, evaluated at each edge in priority order:
    - (a) EN_release = 1, or req_value[owner] = 0: normal release.
    - (b) hcnt == MAX_HOLD-1: timeout.
  - On exit:
    - ptr <= (owner+1) mod 8.
    - gnt_value, gnt_idx, gnt_valid <= 0.
    - state -> GAP.
    - timeout_pulse <= 1 only for exit (b).
- **GAP**
  - One turnaround cycle with all grant outputs zero.
  - timeout_pulse returns to 0 at the next edge.
  - GAP -> IDLE unconditionally; no arbitration happens in GAP.
- Boundary and corner cases:
  - EN_release while not in GRANT: ignored, no state change.
  - Release and expiry on the same edge: treated as a normal release; timeout_pulse stays 0.
  - Requests changing while in GRANT: no effect, except a drop of req_value[owner].
  - A requester that timed out may win again later. It gets no preference because ptr has advanced past it.
  - MAX_HOLD = 1: every grant lasts exactly one cycle unless released in that same cycle.
- Reset (RST_N = 0, at any time including mid-grant), takes effect immediately without waiting for CLK:
  - state = IDLE, ptr = 0, hcnt = 0.
  - gnt_value = 0, gnt_idx = 0, gnt_valid = 0, RDY_release = 0, timeout_pulse = 0.
  - The first arbitration after reset deasserts gives requester 0 highest priority.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Request-to-grant latency: a request sampled in IDLE at edge n gives a grant visible after edge n.
- Grant duration: a grant visible from edge g with no release lasts exactly MAX_HOLD cycles. It clears at edge g+MAX_HOLD, when timeout_pulse rises for one cycle.
- Release-to-next-grant: release sampled at edge e clears the grant after e; GAP occupies e..e+1; IDLE arbitrates at e+2. Minimum two idle cycles between consecutive grants.
- Steady-state throughput with always-pending requests and one-cycle holds: one grant per 3 cycles.

## Test plan
- Reset: assert RST_N = 0 mid-grant (gnt_value = 8'b00100000) -> all outputs 0 immediately, before the next CLK edge. After release of reset, req_value = 8'hFF -> first gnt_idx = 0.
- Single request: IDLE, req_value = 8'b00100000 -> next edge gnt_value = 8'b00100000, gnt_idx = 5, gnt_valid = 1, RDY_release = 1.
- Round-robin fairness: req_value = 8'hFF held, EN_release pulsed on the first cycle of each grant -> gnt_idx sequence 0,1,2,3,4,5,6,7,0, each grant separated by 2 zero cycles.
- Pointer wrap: grant idx 5 then release (ptr = 6), req_value = 8'b00000011 -> gnt_idx = 0. Release again, same requests -> gnt_idx = 1.
- Timeout, MAX_HOLD = 4: req_value = 8'b00001000 held, no release -> gnt_valid high exactly 4 cycles, timeout_pulse = 1 for one cycle as the grant clears, then ptr = 4 and re-grant of idx 3 two cycles later.
- Corner events:
  - EN_release asserted on the same edge as hcnt = MAX_HOLD-1 -> grant clears, timeout_pulse stays 0.
  - EN_release in IDLE -> no change.
  - Owner drops req_value[owner] mid-grant -> grant clears next edge, timeout_pulse = 0.
